// File: rtl/mxint_accumulator_arbiter.sv
// mxint_accumulator_arbiter
//   Shares a single mxint_accumulator between NUM_REQ MxInt block streams.
//   One requester owns the accumulator input for a whole group of IN_DEPTH
//   beats. Each finished group pushes its owner ID into a small FIFO, so the
//   accumulator results that come out later can be tagged with their owner.
//   The data path is a pure combinational mux and adds no latency.
//
// Build option:
//   MXINT_ACC_ARB_FIXED_PRIO_EN - when defined, the lowest-index valid
//   requester wins. When undefined (default), arbitration is round-robin
//   starting at the requester after the last one served.
module mxint_accumulator_arbiter #(
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned DATA_PRECISION_0 = 8,
    parameter int unsigned DATA_PRECISION_1 = 4,
    parameter int unsigned BLOCK_SIZE       = 4,
    parameter int unsigned IN_DEPTH         = 2,
    parameter int unsigned ID_FIFO_DEPTH    = 4
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [NUM_REQ*BLOCK_SIZE*DATA_PRECISION_0-1:0]     req_mdata,
    input  logic [NUM_REQ*DATA_PRECISION_1-1:0]                req_edata,
    input  logic [NUM_REQ-1:0]                                 req_valid,
    output logic [NUM_REQ-1:0]                                 req_ready,
    output logic signed [DATA_PRECISION_0-1:0]                 acc_mdata [BLOCK_SIZE],
    output logic [DATA_PRECISION_1-1:0]                        acc_edata,
    output logic                                               acc_valid,
    input  logic                                               acc_ready,
    input  logic                                               acc_out_valid,
    output logic                                               acc_out_ready,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [$clog2(NUM_REQ)-1:0]                         out_id,
    output logic                                               busy
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int unsigned PW  = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
    localparam int unsigned OW  = $clog2(ID_FIFO_DEPTH + 1);
    localparam int unsigned LW  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    localparam logic [CW-1:0]  LAST_BEAT = CW'(IN_DEPTH - 1);
    localparam logic [IDW-1:0] LAST_REQ  = IDW'(NUM_REQ - 1);
    localparam logic [PW-1:0]  LAST_SLOT = PW'(ID_FIFO_DEPTH - 1);
    localparam logic [OW-1:0]  FULL_CNT  = OW'(ID_FIFO_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [IDW-1:0]   r_grant;
    logic [IDW-1:0]   r_rr_ptr;
    logic [CW-1:0]    r_beat_cnt;

    logic [IDW-1:0]   r_id_mem [ID_FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [OW-1:0]    r_count;

    logic             w_win_found;
    logic [IDW-1:0]   w_win_id;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_beat;
    logic             w_last_beat;
    logic             w_grant_load;
    logic             w_push;
    logic             w_pop;

    assign w_fifo_full  = (r_count == FULL_CNT);
    assign w_fifo_empty = (r_count == '0);
    assign w_beat       = acc_valid && acc_ready;
    assign w_last_beat  = (r_beat_cnt == LAST_BEAT);
    assign w_pop        = acc_out_valid && out_ready && !w_fifo_empty;

`ifdef MXINT_ACC_ARB_FIXED_PRIO_EN
    // Winner selection: lowest-index valid requester.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_win_found && req_valid[IDW'(i)]) begin
                w_win_found = 1'b1;
                w_win_id    = IDW'(i);
            end
        end
    end
`else
    int unsigned w_idx;

    // Winner selection: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = (32'(r_rr_ptr) + i) % NUM_REQ;
            if (!w_win_found && req_valid[IDW'(w_idx)]) begin
                w_win_found = 1'b1;
                w_win_id    = IDW'(w_idx);
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: grant from IDLE when a slot is free, release after the last beat.
    always_comb begin
        w_next_state = r_state;
        w_grant_load = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_found && !w_fifo_full) begin
                    w_grant_load = 1'b1;
                    w_next_state = BURST;
                end
            end
            BURST: begin
                if (w_beat && w_last_beat) begin
                    w_push       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Grant, beat counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_grant_load) begin
                r_grant    <= w_win_id;
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
            end
            if (w_push) begin
                r_rr_ptr <= (r_grant == LAST_REQ) ? '0 : r_grant + 1'b1;
            end
        end
    end

    // Input mux: only the granted requester reaches the accumulator, and only in BURST.
    always_comb begin
        req_ready = '0;
        acc_valid = 1'b0;
        acc_edata = '0;
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
            acc_mdata[LW'(i)] = '0;
        end
        if (r_state == BURST) begin
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                if (r_grant == IDW'(r)) begin
                    for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
                        acc_mdata[LW'(i)] =
                            req_mdata[(r*BLOCK_SIZE + i)*DATA_PRECISION_0 +: DATA_PRECISION_0];
                    end
                    acc_edata          = req_edata[r*DATA_PRECISION_1 +: DATA_PRECISION_1];
                    acc_valid          = req_valid[IDW'(r)];
                    req_ready[IDW'(r)] = acc_ready;
                end
            end
        end
    end

    // ID FIFO storage: owner of each completed group.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_id_mem[r_wr_ptr] <= r_grant;
        end
    end

    // ID FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid     = acc_out_valid;
    assign acc_out_ready = out_ready;
    assign out_id        = w_fifo_empty ? '0 : r_id_mem[r_rd_ptr];
    assign busy          = (r_state == BURST) || !w_fifo_empty;

endmodule

// File: tb/tb_mxint_accumulator_arbiter.sv
// Testbench for mxint_accumulator_arbiter. The bench plays the requesters and
// the accumulator; expected owners are queued when work is issued and popped
// when beats and tagged results appear.
module tb_mxint_accumulator_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned DP0 = 8;
    localparam int unsigned DP1 = 4;
    localparam int unsigned BS  = 4;
    localparam int unsigned IND = 2;
    localparam int unsigned FD  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic [NR*BS*DP0-1:0]     req_mdata;
    logic [NR*DP1-1:0]        req_edata;
    logic [NR-1:0]            req_valid;
    logic [NR-1:0]            req_ready;
    logic signed [DP0-1:0]    acc_mdata [BS];
    logic [DP1-1:0]           acc_edata;
    logic                     acc_valid;
    logic                     acc_ready;
    logic                     acc_out_valid;
    logic                     acc_out_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [1:0]               out_id;
    logic                     busy;

    mxint_accumulator_arbiter #(
        .NUM_REQ          (NR),
        .DATA_PRECISION_0 (DP0),
        .DATA_PRECISION_1 (DP1),
        .BLOCK_SIZE       (BS),
        .IN_DEPTH         (IND),
        .ID_FIFO_DEPTH    (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_mdata     (req_mdata),
        .req_edata     (req_edata),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .acc_mdata     (acc_mdata),
        .acc_edata     (acc_edata),
        .acc_valid     (acc_valid),
        .acc_ready     (acc_ready),
        .acc_out_valid (acc_out_valid),
        .acc_out_ready (acc_out_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_id        (out_id),
        .busy          (busy)
    );

    int total = 0;
    int bad   = 0;

    int left [NR];
    bit hold [NR];
    int bcnt;
    int pending;
    int cur_owner;
    bit rand_acc;
    int exp_grant [$];
    int exp_id    [$];

    function automatic logic [DP0-1:0] m_lane(int r, int i);
        return DP0'(r*37 + i*11 + 200);
    endfunction

    function automatic logic [DP1-1:0] e_val(int r);
        return DP1'(r + 3);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_grp(input int id);
        exp_grant.push_back(id);
        exp_id.push_back(id);
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            req_valid[r] = (left[r] > 0) && !hold[r];
        end
        acc_out_valid = (pending > 0);
        if (rand_acc) acc_ready = ($urandom_range(0, 3) != 0);
    endtask

    function automatic bit all_left_zero();
        for (int r = 0; r < NR; r++) begin
            if (left[r] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: check at negedge, update requester/accumulator models after posedge.
    task automatic tick();
        logic [NR-1:0]     hs;
        bit                beat;
        bit                ohs;
        logic [BS*DP0-1:0] mobs;
        logic [BS*DP0-1:0] mexp;
        int                e;
        @(negedge clk);
        hs   = req_valid & req_ready;
        beat = (acc_valid === 1'b1) && (acc_ready === 1'b1);
        ohs  = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (beat) begin
            if (bcnt == 0) begin
                chk("grant_expected", 64'(exp_grant.size() != 0), 64'd1);
                cur_owner = (exp_grant.size() != 0) ? exp_grant.pop_front() : 0;
            end
            chk("beat_req_ready", 64'(req_ready), 64'd1 << cur_owner);
            chk("beat_edata", 64'(acc_edata), 64'(e_val(cur_owner)));
            for (int i = 0; i < BS; i++) begin
                mobs[i*DP0 +: DP0] = acc_mdata[2'(i)];
                mexp[i*DP0 +: DP0] = m_lane(cur_owner, i);
            end
            chk("beat_mdata", 64'(mobs), 64'(mexp));
        end
        if (ohs) begin
            chk("id_expected", 64'(exp_id.size() != 0), 64'd1);
            if (exp_id.size() != 0) begin
                e = exp_id.pop_front();
                chk("out_id", 64'(out_id), 64'(e));
            end
        end
        if (acc_out_valid) chk("result_has_owner", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int r = 0; r < NR; r++) left[r] = 0;
            bcnt    = 0;
            pending = 0;
        end else begin
            for (int r = 0; r < NR; r++) begin
                if (hs[r]) left[r]--;
            end
            if (beat) begin
                bcnt++;
                if (bcnt == IND) begin
                    bcnt = 0;
                    pending++;
                end
            end
            if (ohs) pending--;
        end
        drive();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = all_left_zero() && (pending == 0) && (busy === 1'b0)
                   && (exp_grant.size() == 0) && (exp_id.size() == 0);
        end
        chk({tag, "_drain"}, 64'(done), 64'd1);
    endtask

    task automatic tick_until_left(input int r, input int val, input int budget, input string tag);
        int n;
        n = 0;
        while (left[r] != val && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_reached"}, 64'(left[r]), 64'(val));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_acc_valid"}, 64'(acc_valid), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_id"},    64'(out_id),    64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < NR; r++) begin
            for (int i = 0; i < BS; i++) begin
                req_mdata[(r*BS + i)*DP0 +: DP0] = m_lane(r, i);
            end
            req_edata[r*DP1 +: DP1] = e_val(r);
            left[r] = 0;
            hold[r] = 1'b0;
        end
        rst       = 1'b1;
        acc_ready = 1'b1;
        out_ready = 1'b1;
        rand_acc  = 1'b0;
        bcnt      = 0;
        pending   = 0;
        cur_owner = 0;
        drive();
        repeat (3) tick();
        chk_quiet("reset");
        rst = 1'b0;
        drive();

        // All four requesting with accumulator backpressure; req 0 has two groups.
        left[0] = 4; left[1] = 2; left[2] = 2; left[3] = 2;
`ifdef MXINT_ACC_ARB_FIXED_PRIO_EN
        expect_grp(0); expect_grp(0); expect_grp(1); expect_grp(2); expect_grp(3);
`else
        expect_grp(0); expect_grp(1); expect_grp(2); expect_grp(3); expect_grp(0);
`endif
        rand_acc = 1'b1;
        drive();
        wait_idle(300, "arb_order");
        rand_acc  = 1'b0;
        acc_ready = 1'b1;
        drive();

        // Single requester 2, exponent 5.
        left[2] = 2;
        expect_grp(2);
        drive();
        wait_idle(60, "single");

`ifdef MXINT_ACC_ARB_FIXED_PRIO_EN
        // Requester 0 keeps winning while it is valid.
        left[0] = 6; left[1] = 2; left[3] = 2;
        expect_grp(0); expect_grp(0); expect_grp(0); expect_grp(1); expect_grp(3);
        drive();
        wait_idle(100, "starve");
`endif

        // Results not consumed: ID FIFO fills after four groups.
        out_ready = 1'b0;
        left[1]   = 10;
        repeat (5) expect_grp(1);
        drive();
        repeat (20) tick();
        chk("full_left",          64'(left[1]),       64'd2);
        chk("full_acc_valid",     64'(acc_valid),     64'd0);
        chk("full_req_ready",     64'(req_ready),     64'd0);
        chk("full_busy",          64'(busy),          64'd1);
        chk("full_out_valid",     64'(out_valid),     64'd1);
        chk("full_acc_out_ready", 64'(acc_out_ready), 64'd0);
        out_ready = 1'b1;
        drive();
        tick();
        out_ready = 1'b0;
        drive();
        repeat (6) tick();
        chk("fifth_grant_left", 64'(left[1]), 64'd0);
        out_ready = 1'b1;
        drive();
        wait_idle(100, "backpressure");

        // Granted requester 3 drops valid mid-group; requester 0 must wait.
        left[3] = 2;
        expect_grp(3);
        drive();
        tick_until_left(3, 1, 20, "hold_first_beat");
        hold[3] = 1'b1;
        left[0] = 2;
        expect_grp(0);
        drive();
        repeat (3) begin
            tick();
            chk("hold_acc_valid", 64'(acc_valid), 64'd0);
            chk("hold_req_ready", 64'(req_ready), 64'h8);
        end
        hold[3] = 1'b0;
        drive();
        wait_idle(60, "hold");

        // Reset in the middle of a group.
        left[1] = 2;
        expect_grp(1);
        drive();
        tick_until_left(1, 1, 20, "rst_first_beat");
        rst = 1'b1;
        drive();
        tick();
        chk_quiet("midrst");
        exp_grant.delete();
        exp_id.delete();
        rst = 1'b0;
        drive();

        // Pointer restarts at 0 after reset.
        left[0] = 2; left[1] = 2; left[2] = 2; left[3] = 2;
        expect_grp(0); expect_grp(1); expect_grp(2); expect_grp(3);
        drive();
        wait_idle(120, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
